// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, functional-unit indices, default width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_DATA_W = 8;

    // Result-stage FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Functional-unit positions on the result bus
    localparam int SEL_FWD   = 0;
    localparam int SEL_ADD   = 1;
    localparam int SEL_AND   = 2;
    localparam int SEL_OR    = 3;
    localparam int SEL_MUL   = 4;
    localparam int SEL_SHIFT = 5;

endpackage

// File: rtl/alu_wait_timer.sv
// Clear/enable up-counter that flags when TIMEOUT-1 has been reached.
// Latency: tc is combinational from the registered count; count updates on the next edge.
// Backpressure: none; holds at terminal count until cleared or reset.
//
// Ports: clk, reset (sync, active-high), clr (load zero), en (count), tc (count == TIMEOUT-1).
module alu_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] wait_cnt;

    assign tc = (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (en && !tc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result select: picks one of NUM_UNITS unit results by SEL, flags zero/error.
// Latency: 1 cycle for ready units; k+2 cycles when the selected unit's done first rises in WAIT cycle k.
// Backpressure: BUSY is high while waiting on a multi-cycle unit; START is ignored until it drops.
//
// Ports: CLK, RESET (sync, active-high), START/SEL issue, IN_BUS (unit i at [i*DATA_W +: DATA_W]),
//        UNIT_DONE per unit; OUT/ZERO registered result, OUT_VALID/ERR completion pulses, BUSY.
// Build option: define ALU_RESULT_TIMEOUT_EN to abort a WAIT with ERR after TIMEOUT cycles.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W    = ALU_DATA_W,
    parameter int NUM_UNITS = 8,
    parameter int SEL_W     = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        START,
    input  logic [SEL_W-1:0]            SEL,
    input  logic [NUM_UNITS*DATA_W-1:0] IN_BUS,
    input  logic [NUM_UNITS-1:0]        UNIT_DONE,
    output logic [DATA_W-1:0]           OUT,
    output logic                        OUT_VALID,
    output logic                        ZERO,
    output logic                        BUSY,
    output logic                        ERR
);

    logic [0:0]       state;
    logic [SEL_W-1:0] sel_q;

    logic [SEL_W-1:0]  act_sel;
    logic [DATA_W-1:0] act_slice;
    logic              act_done;
    logic              sel_legal;
    logic              timeout_hit;

    // In IDLE the live SEL drives the mux; in WAIT the latched index does,
    // so SEL wiggles and unrelated done flags during a wait have no effect.
    always_comb begin
        act_sel   = (state == ST_IDLE) ? SEL : sel_q;
        act_slice = '0;
        act_done  = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (32'(act_sel) == i) begin
                act_slice = IN_BUS[i*DATA_W +: DATA_W];
                act_done  = UNIT_DONE[i];
            end
        end
    end

    // Out-of-range selects take a defined error path instead of muxing X.
    assign sel_legal = (32'(SEL) < NUM_UNITS);

`ifdef ALU_RESULT_TIMEOUT_EN
    logic timer_clr;
    logic timer_en;
    logic timer_tc;

    assign timer_clr = (state == ST_IDLE) && START && sel_legal && !act_done;
    assign timer_en  = (state == ST_WAIT) && !act_done;

    alu_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (CLK),
        .reset (RESET),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    assign timeout_hit = (state == ST_WAIT) && !act_done && timer_tc;
`else
    // No abort path: a wait lasts until done or RESET.
    wire timeout_unused = (TIMEOUT > 0);
    assign timeout_hit = 1'b0;
`endif

    assign BUSY = (state == ST_WAIT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_IDLE;
            sel_q     <= '0;
            OUT       <= '0;
            ZERO      <= 1'b1;
            OUT_VALID <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            ERR       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        if (!sel_legal) begin
                            // OUT/ZERO keep the last good result
                            OUT_VALID <= 1'b1;
                            ERR       <= 1'b1;
                        end else if (act_done) begin
                            OUT       <= act_slice;
                            ZERO      <= (act_slice == '0);
                            OUT_VALID <= 1'b1;
                        end else begin
                            sel_q <= SEL;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (act_done) begin
                        OUT       <= act_slice;
                        ZERO      <= (act_slice == '0);
                        OUT_VALID <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        OUT_VALID <= 1'b1;
                        ERR       <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised scoreboard bench for alu_result_stage (6 units, TIMEOUT=4).
// Driver pushes the expected completion (value, zero, err, cycle) per issued op;
// a negedge monitor pops one entry for every OUT_VALID pulse.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int DW = 8;
    localparam int NU = 6;
    localparam int SW = 3;
    localparam int TO = 4;

    logic           CLK = 1'b0;
    logic           RESET;
    logic           START;
    logic [SW-1:0]  SEL;
    logic [NU*DW-1:0] IN_BUS;
    logic [NU-1:0]  UNIT_DONE;
    logic [DW-1:0]  OUT;
    logic           OUT_VALID;
    logic           ZERO;
    logic           BUSY;
    logic           ERR;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] out;
        logic          zero;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // architectural state of the reference model
    logic [DW-1:0] m_out;
    logic          m_zero;

    alu_result_stage #(
        .DATA_W    (DW),
        .NUM_UNITS (NU),
        .SEL_W     (SW),
        .TIMEOUT   (TO)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SEL       (SEL),
        .IN_BUS    (IN_BUS),
        .UNIT_DONE (UNIT_DONE),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .ZERO      (ZERO),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic void expect_ok(input logic [DW-1:0] v, input int c);
        exp_t e;
        m_out  = v;
        m_zero = (v == '0);
        e.out = m_out; e.zero = m_zero; e.err = 1'b0; e.cyc = c;
        sb.push_back(e);
    endfunction

    function automatic void expect_err(input int c);
        exp_t e;
        e.out = m_out; e.zero = m_zero; e.err = 1'b1; e.cyc = c;
        sb.push_back(e);
    endfunction

    task automatic scramble_bus();
        for (int i = 0; i < NU; i++) IN_BUS[i*DW +: DW] = DW'($urandom);
    endtask

    // One operation on unit s. d=0: unit ready at issue; d>0: done rises in WAIT cycle d.
    // poke holds START high with a different legal SEL during the wait.
    task automatic do_op(input int s, input int d, input bit poke, input logic [DW-1:0] val);
        int c;
        logic [NU-1:0] dn;
        c = cyc;
        scramble_bus();
        dn    = NU'($urandom);
        START = 1'b1;
        SEL   = SW'(s);
        if (s >= NU) begin
            UNIT_DONE = dn;
            expect_err(c + 1);
            step();
        end else if (d == 0) begin
            dn[s] = 1'b1;
            UNIT_DONE = dn;
            IN_BUS[s*DW +: DW] = val;
            expect_ok(val, c + 1);
            step();
            check("busy_single", 32'(BUSY), 32'd0);
        end else begin
            dn[s] = 1'b0;
            UNIT_DONE = dn;
            step();
            for (int k = 0; k < 64; k++) begin
                check("busy_wait", 32'(BUSY), 32'd1);
                scramble_bus();
                if (poke) begin
                    START = 1'b1;
                    SEL   = SW'($urandom_range(0, NU - 1));
                    dn    = '1;
                end else begin
                    START = 1'b0;
                    dn    = NU'($urandom);
                end
`ifdef ALU_RESULT_TIMEOUT_EN
                if (d >= TO && k == TO - 1) begin
                    dn[s] = 1'b0;
                    UNIT_DONE = dn;
                    expect_err(c + 1 + TO);
                    step();
                    break;
                end
`endif
                if (k == d) begin
                    dn[s] = 1'b1;
                    UNIT_DONE = dn;
                    IN_BUS[s*DW +: DW] = val;
                    expect_ok(val, c + 2 + d);
                    step();
                    scramble_bus();
                    break;
                end
                dn[s] = 1'b0;
                UNIT_DONE = dn;
                step();
            end
        end
        START = 1'b0;
        check("busy_after", 32'(BUSY), 32'd0);
    endtask

    always @(negedge CLK) begin
        if (!RESET) begin
            if (OUT_VALID) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: OUT_VALID=1 out=%h err=%b with nothing pending, cycle %0d",
                             OUT, ERR, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (OUT !== mon_e.out || ZERO !== mon_e.zero || ERR !== mon_e.err || cyc != mon_e.cyc) begin
                        fails++;
                        $display("FAIL result: got out=%h zero=%b err=%b cyc=%0d, expected out=%h zero=%b err=%b cyc=%0d",
                                 OUT, ZERO, ERR, cyc, mon_e.out, mon_e.zero, mon_e.err, mon_e.cyc);
                    end
                end
            end else if (ERR) begin
                tests++;
                fails++;
                $display("FAIL err_no_valid: ERR=1 while OUT_VALID=0, cycle %0d", cyc);
            end
        end
    end

    initial begin
        int s;
        int d;
        logic [DW-1:0] v;

        // Reset with an issue attempt held on the inputs
        RESET = 1'b1;
        START = 1'b1;
        SEL   = SW'(SEL_ADD);
        UNIT_DONE = '1;
        scramble_bus();
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_no_valid", 32'(OUT_VALID), 32'd0);
        end
        check("reset_out",  32'(OUT),  32'd0);
        check("reset_zero", 32'(ZERO), 32'd1);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_err",  32'(ERR),  32'd0);
        RESET  = 1'b0;
        START  = 1'b0;
        m_out  = '0;
        m_zero = 1'b1;
        step();

        // Directed cases
        do_op(SEL_ADD, 0, 1'b0, 8'h2A);
        do_op(SEL_AND, 0, 1'b0, 8'h00);
        do_op(SEL_MUL, 3, 1'b1, 8'h90);
        do_op(6, 0, 1'b0, 8'h00);
        do_op(7, 0, 1'b0, 8'h00);
        do_op(SEL_OR, 0, 1'b0, 8'h5C);

`ifdef ALU_RESULT_TIMEOUT_EN
        do_op(SEL_SHIFT, 20, 1'b0, 8'h11);
`else
        // Without the abort path the wait only ends on RESET
        START = 1'b1;
        SEL   = SW'(SEL_SHIFT);
        UNIT_DONE = '0;
        step();
        START = 1'b0;
        for (int k = 0; k < 50; k++) begin
            UNIT_DONE = NU'($urandom) & ~(NU'(1) << SEL_SHIFT);
            check("busy_hold", 32'(BUSY), 32'd1);
            step();
        end
        RESET = 1'b1;
        step();
        RESET  = 1'b0;
        m_out  = '0;
        m_zero = 1'b1;
        check("busy_reset_clear", 32'(BUSY), 32'd0);
`endif

        // RESET during the second WAIT cycle: abort with no completion
        do_op(SEL_FWD, 0, 1'b0, 8'h33);
        START = 1'b1;
        SEL   = SW'(SEL_MUL);
        UNIT_DONE = '0;
        step();
        START = 1'b0;
        step();
        RESET = 1'b1;
        step();
        RESET  = 1'b0;
        m_out  = '0;
        m_zero = 1'b1;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_out",  32'(OUT),  32'd0);
        check("abort_zero", 32'(ZERO), 32'd1);
        UNIT_DONE = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_idle_busy", 32'(BUSY), 32'd0);
        end

        // Randomised traffic, back-to-back where ops allow
        for (int n = 0; n < 300; n++) begin
            s = $urandom_range(0, 7);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
            v = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            do_op(s, d, 1'($urandom_range(0, 1)), v);
            if ($urandom_range(0, 3) == 0) step();
        end

        UNIT_DONE = '0;
        for (int k = 0; k < 4; k++) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
